// File: rtl/alu_exec_unit_if.sv
// Request/response bundle for alu_exec_unit.
// Request side is valid/ready in; result side is valid/ready out.
interface alu_exec_unit_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [5:0]       func_code;
  logic [1:0]       alu_op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             zero;
  logic [3:0]       alu_ctl;
  logic             illegal;

  modport master (
    output in_valid, func_code, alu_op, a, b, out_ready,
    input  in_ready, out_valid, result, result_hi,
    input  zero, alu_ctl, illegal
  );

  modport slave (
    input  in_valid, func_code, alu_op, a, b, out_ready,
    output in_ready, out_valid, result, result_hi,
    output zero, alu_ctl, illegal
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Handshaked ALU stage: decode + single-cycle ops, iterative multu.
// Define ALU_EXEC_MULT_EN to build the shift-add multiplier.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       reset,
  alu_exec_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam logic [3:0] CTL_AND = 4'b0000;
  localparam logic [3:0] CTL_OR  = 4'b0001;
  localparam logic [3:0] CTL_ADD = 4'b0010;
  localparam logic [3:0] CTL_SUB = 4'b0110;
  localparam logic [3:0] CTL_SLT = 4'b0111;
  localparam logic [3:0] CTL_MUL = 4'b1000;
  localparam logic [3:0] CTL_NOR = 4'b1100;
  localparam logic [3:0] CTL_ILL = 4'b1111;

  state_t           state;
  state_t           nxt;
  logic             accept;
  logic [3:0]       dec_ctl;
  logic             dec_ill;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] res_q;
  logic             zero_q;
  logic [3:0]       ctl_q;
  logic             ill_q;

  assign accept = bus.in_valid && (state == IDLE);

  always_comb begin
    dec_ctl = CTL_ILL;
    dec_ill = 1'b0;
    unique case (1'b1)
      (bus.alu_op == 2'b00): dec_ctl = CTL_ADD;
      bus.alu_op[0]:         dec_ctl = CTL_SUB;
      default: begin
        case (bus.func_code)
          6'b100000: dec_ctl = CTL_ADD;
          6'b100010: dec_ctl = CTL_SUB;
          6'b100100: dec_ctl = CTL_AND;
          6'b100101: dec_ctl = CTL_OR;
          6'b101010: dec_ctl = CTL_SLT;
          6'b100111: dec_ctl = CTL_NOR;
`ifdef ALU_EXEC_MULT_EN
          6'b011001: dec_ctl = CTL_MUL;
`endif
          default:   dec_ill = 1'b1;
        endcase
      end
    endcase
  end

  // multu and illegal leave alu_res at 0
  always_comb begin
    alu_res = '0;
    case (dec_ctl)
      CTL_ADD: alu_res = bus.a + bus.b;
      CTL_SUB: alu_res = bus.a - bus.b;
      CTL_AND: alu_res = bus.a & bus.b;
      CTL_OR:  alu_res = bus.a | bus.b;
      CTL_NOR: alu_res = ~(bus.a | bus.b);
      CTL_SLT: alu_res = {{(WIDTH-1){1'b0}},
                          $signed(bus.a) < $signed(bus.b)};
      default: alu_res = '0;
    endcase
  end

`ifdef ALU_EXEC_MULT_EN
  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;
  logic [WIDTH-1:0] hi_q;
  logic             is_mul;
  logic             mul_last;

  assign is_mul   = (dec_ctl == CTL_MUL);
  assign mul_last = (cnt == CW'(WIDTH - 1));
  assign sum      = acc_lo[0] ? {1'b0, acc_hi} + {1'b0, mcand}
                              : {1'b0, acc_hi};
  assign step_hi  = sum[WIDTH:1];
  assign step_lo  = {sum[0], acc_lo[WIDTH-1:1]};

  // acc_lo starts as the multiplier and fills with product bits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      cnt    <= '0;
    end else if (accept) begin
      mcand  <= bus.a;
      acc_hi <= '0;
      acc_lo <= bus.b;
      cnt    <= '0;
    end else if (state == BUSY) begin
      acc_hi <= step_hi;
      acc_lo <= step_lo;
      cnt    <= cnt + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
`ifdef ALU_EXEC_MULT_EN
          nxt = is_mul ? BUSY : DONE;
`else
          nxt = DONE;
`endif
        end
      end
      BUSY: begin
`ifdef ALU_EXEC_MULT_EN
        if (mul_last) nxt = DONE;
`else
        nxt = IDLE;
`endif
      end
      DONE: begin
        if (bus.out_ready) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_q  <= '0;
      zero_q <= 1'b1;
      ctl_q  <= 4'b0000;
      ill_q  <= 1'b0;
    end else if (accept) begin
      res_q  <= alu_res;
      zero_q <= (alu_res == '0);
      ctl_q  <= dec_ctl;
      ill_q  <= dec_ill;
`ifdef ALU_EXEC_MULT_EN
    end else if (state == BUSY && mul_last) begin
      res_q  <= step_lo;
      zero_q <= (step_lo == '0);
`endif
    end
  end

`ifdef ALU_EXEC_MULT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      hi_q <= '0;
    else if (accept)
      hi_q <= '0;
    else if (state == BUSY && mul_last)
      hi_q <= step_hi;
  end

  assign bus.result_hi = hi_q;
`else
  assign bus.result_hi = '0;
`endif

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.result    = res_q;
  assign bus.zero      = zero_q;
  assign bus.alu_ctl   = ctl_q;
  assign bus.illegal   = ill_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit (WIDTH=32).
module tb_alu_exec_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  alu_exec_unit_if #(.WIDTH(W)) bus ();

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         z;
    logic [3:0]   ctl;
    logic         ill;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic exp_t model(
    input logic [1:0]   op,
    input logic [5:0]   f,
    input logic [W-1:0] x,
    input logic [W-1:0] y
  );
    exp_t e;
    logic [2*W-1:0] p;
    e.res = '0;
    e.hi  = '0;
    e.ill = 1'b0;
    e.lat = 1;
    e.ctl = 4'b1111;
    p     = '0;
    if (op == 2'b00) begin
      e.ctl = 4'b0010; e.res = x + y;
    end else if (op != 2'b10) begin
      e.ctl = 4'b0110; e.res = x - y;
    end else begin
      case (f)
        6'b100000: begin e.ctl = 4'b0010; e.res = x + y; end
        6'b100010: begin e.ctl = 4'b0110; e.res = x - y; end
        6'b100100: begin e.ctl = 4'b0000; e.res = x & y; end
        6'b100101: begin e.ctl = 4'b0001; e.res = x | y; end
        6'b100111: begin e.ctl = 4'b1100; e.res = ~(x | y); end
        6'b101010: begin
          e.ctl = 4'b0111;
          e.res = ($signed(x) < $signed(y)) ? W'(1) : W'(0);
        end
`ifdef ALU_EXEC_MULT_EN
        6'b011001: begin
          p     = {{W{1'b0}}, x} * {{W{1'b0}}, y};
          e.ctl = 4'b1000;
          e.res = p[W-1:0];
          e.hi  = p[2*W-1:W];
          e.lat = W + 1;
        end
`endif
        default: e.ill = 1'b1;
      endcase
    end
    e.z = (e.res == '0);
    return e;
  endfunction

  task automatic run_op(
    input  logic [1:0]   op,
    input  logic [5:0]   f,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  int           hold,
    output exp_t         got
  );
    exp_t e;
    int   lat;
    bit   busy_rdy;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL idle_in_ready got=%b exp=1", bus.in_ready);
    end
    sb.push_back(model(op, f, x, y));
    bus.alu_op    = op;
    bus.func_code = f;
    bus.a         = x;
    bus.b         = y;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    @(posedge clk);
    #1;
    lat      = 1;
    busy_rdy = 1'b0;
    while (bus.out_valid !== 1'b1 && lat < 200) begin
      if (bus.in_ready !== 1'b0) busy_rdy = 1'b1;
      bus.a         = W'($urandom);
      bus.b         = W'($urandom);
      bus.func_code = 6'($urandom);
      bus.alu_op    = 2'($urandom);
      bus.out_ready = 1'($urandom);
      @(posedge clk);
      #1;
      lat++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    e = sb.pop_front();
    got.res = bus.result;
    got.hi  = bus.result_hi;
    got.z   = bus.zero;
    got.ctl = bus.alu_ctl;
    got.ill = bus.illegal;
    got.lat = lat;
    checks++;
    if (lat != e.lat) begin
      failures++;
      $display("FAIL latency got=%0d exp=%0d", lat, e.lat);
    end
    checks++;
    if (busy_rdy) begin
      failures++;
      $display("FAIL busy_in_ready got=1 exp=0");
    end
    checks++;
    if (got.res !== e.res) begin
      failures++;
      $display("FAIL result got=%h exp=%h", got.res, e.res);
    end
    checks++;
    if (got.hi !== e.hi) begin
      failures++;
      $display("FAIL result_hi got=%h exp=%h", got.hi, e.hi);
    end
    checks++;
    if (got.z !== e.z) begin
      failures++;
      $display("FAIL zero got=%b exp=%b", got.z, e.z);
    end
    checks++;
    if (got.ctl !== e.ctl) begin
      failures++;
      $display("FAIL alu_ctl got=%b exp=%b", got.ctl, e.ctl);
    end
    checks++;
    if (got.ill !== e.ill) begin
      failures++;
      $display("FAIL illegal got=%b exp=%b", got.ill, e.ill);
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({bus.out_valid, bus.in_ready, bus.result, bus.result_hi,
           bus.zero, bus.alu_ctl, bus.illegal} !==
          {1'b1, 1'b0, e.res, e.hi, e.z, e.ctl, e.ill}) begin
        failures++;
        $display("FAIL hold_stable cyc=%0d vld=%b rdy=%b res=%h exp=%h",
                 i, bus.out_valid, bus.in_ready, bus.result, e.res);
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    checks++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
      failures++;
      $display("FAIL drain vld=%b rdy=%b exp vld=0 rdy=1",
               bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.out_valid, bus.result, bus.result_hi, bus.zero,
         bus.alu_ctl, bus.illegal} !==
        {1'b0, W'(0), W'(0), 1'b1, 4'b0000, 1'b0}) begin
      failures++;
      $display("FAIL reset_vals vld=%b res=%h hi=%h z=%b ctl=%b ill=%b",
               bus.out_valid, bus.result, bus.result_hi, bus.zero,
               bus.alu_ctl, bus.illegal);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready);
    end
  endtask

  task automatic test_add_wrap();
    exp_t g;
    run_op(2'b10, 6'b100000, 32'hFFFF_FFFF, 32'h1, 0, g);
    checks++;
    if ({g.res, g.z, g.ctl, g.lat} !==
        {32'h0, 1'b1, 4'b0010, 32'd1}) begin
      failures++;
      $display("FAIL add_wrap res=%h z=%b ctl=%b lat=%0d exp 0/1/0010/1",
               g.res, g.z, g.ctl, g.lat);
    end
  endtask

  task automatic test_slt();
    exp_t g;
    run_op(2'b10, 6'b101010, 32'hFFFF_FFFE, 32'h1, 0, g);
    checks++;
    if ({g.res, g.ctl} !== {32'h1, 4'b0111}) begin
      failures++;
      $display("FAIL slt_neg res=%h ctl=%b exp 1/0111", g.res, g.ctl);
    end
    run_op(2'b10, 6'b101010, 32'h1, 32'hFFFF_FFFE, 0, g);
    checks++;
    if ({g.res, g.z} !== {32'h0, 1'b1}) begin
      failures++;
      $display("FAIL slt_swap res=%h z=%b exp 0/1", g.res, g.z);
    end
  endtask

  task automatic test_ops();
    logic [1:0] ops [7];
    logic [5:0] fns [7];
    exp_t g;
    ops = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b10, 2'b10, 2'b10};
    fns = '{6'h3f, 6'h00, 6'h15, 6'b100010, 6'b100100,
            6'b100101, 6'b100111};
    for (int i = 0; i < 7; i++) begin
      for (int k = 0; k < 2; k++)
        run_op(ops[i], fns[i], W'($urandom), W'($urandom), 0, g);
    end
    run_op(2'b10, 6'b100010, 32'h1234_5678, 32'h1234_5678, 0, g);
  endtask

  task automatic test_illegal();
    exp_t g;
    run_op(2'b10, 6'b111111, 32'hDEAD_BEEF, 32'h5, 0, g);
    checks++;
    if ({g.ill, g.ctl, g.res, g.z} !== {1'b1, 4'b1111, 32'h0, 1'b1}) begin
      failures++;
      $display("FAIL illegal_ff ill=%b ctl=%b res=%h", g.ill, g.ctl, g.res);
    end
`ifndef ALU_EXEC_MULT_EN
    run_op(2'b10, 6'b011001, 32'hFFFF_FFFF, 32'h2, 0, g);
    checks++;
    if ({g.ill, g.ctl, g.res, g.hi, g.lat} !==
        {1'b1, 4'b1111, 32'h0, 32'h0, 32'd1}) begin
      failures++;
      $display("FAIL multu_off ill=%b ctl=%b res=%h lat=%0d",
               g.ill, g.ctl, g.res, g.lat);
    end
`endif
  endtask

`ifdef ALU_EXEC_MULT_EN
  task automatic test_mult();
    exp_t g;
    run_op(2'b10, 6'b011001, 32'hFFFF_FFFF, 32'h2, 0, g);
    checks++;
    if ({g.hi, g.res, g.lat} !== {32'h1, 32'hFFFF_FFFE, 32'd33}) begin
      failures++;
      $display("FAIL multu hi=%h lo=%h lat=%0d exp 1/fffffffe/33",
               g.hi, g.res, g.lat);
    end
    run_op(2'b10, 6'b011001, W'($urandom), W'($urandom), 0, g);
    run_op(2'b10, 6'b011001, 32'h0, W'($urandom), 0, g);
  endtask
`endif

  task automatic test_stall();
    exp_t g;
    run_op(2'b10, 6'b100101, 32'hA5A5_0000, 32'h0000_5A5A, 5, g);
`ifdef ALU_EXEC_MULT_EN
    run_op(2'b10, 6'b011001, 32'h0001_0003, 32'h0002_0005, 5, g);
`endif
  endtask

  task automatic test_back_to_back();
    exp_t g;
    for (int i = 0; i < 6; i++)
      run_op(2'b10, 6'b100000, W'($urandom), W'($urandom), 0, g);
  endtask

  task automatic test_reset_mid();
    exp_t g;
    @(negedge clk);
    bus.alu_op   = 2'b10;
`ifdef ALU_EXEC_MULT_EN
    bus.func_code = 6'b011001;
`else
    bus.func_code = 6'b100000;
`endif
    bus.a        = 32'h5;
    bus.b        = 32'h6;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.out_valid, bus.result, bus.in_ready} !==
        {1'b0, W'(0), 1'b1}) begin
      failures++;
      $display("FAIL reset_mid vld=%b res=%h rdy=%b exp 0/0/1",
               bus.out_valid, bus.result, bus.in_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    run_op(2'b10, 6'b100000, 32'h3, 32'h4, 0, g);
    checks++;
    if ({g.res, g.lat} !== {32'h7, 32'd1}) begin
      failures++;
      $display("FAIL post_reset_add res=%h lat=%0d exp 7/1", g.res, g.lat);
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.alu_op    = 2'b00;
    bus.func_code = 6'h00;
    bus.a         = '0;
    bus.b         = '0;
    test_reset();
    test_add_wrap();
    test_slt();
    test_ops();
    test_illegal();
`ifdef ALU_EXEC_MULT_EN
    test_mult();
`endif
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 Parameter WIDTH, default 32: operand/result width in bits; legal range 8..64.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  request present on func_code/alu_op/a/b.
REQ-005 in_ready  output  1  unit can accept a request this cycle.
REQ-006 func_code  input  6  R-type funct field.
REQ-007 alu_op  input  2  main-decoder ALU op class.
REQ-008 a, b  input  WIDTH each  operands (rs, rt).
REQ-009 out_valid  output  1  result registers hold a completed operation.
REQ-010 out_ready  input  1  consumer accepts result this cycle.
REQ-011 result  output  WIDTH  operation result (low half for multiply).
REQ-012 result_hi  output  WIDTH  high half of product; 0 for non-multiply ops.
REQ-013 zero  output  1  result == 0.
REQ-014 alu_ctl  output  4  registered decoded control code of the accepted operation.
REQ-015 illegal  output  1  accepted operation did not decode.

Function
REQ-016 Transfer in occurs when in_valid && in_ready; transfer out occurs when out_valid && out_ready.
REQ-017 Decode: alu_op 00 -> add (0010); 01 or 11 -> subtract (0110); 10 -> by func_code: 100000 add (0010), 100010 sub (0110), 100100 and (0000), 100101 or (0001), 101010 slt (0111), 100111 nor (1100), 011001 multu (1000, MULT_EN only).
REQ-018 Any other alu_op 10 func_code -> alu_ctl 1111, illegal=1, result=0, result_hi=0, latency 1.
REQ-019 Add/sub wrap modulo 2^WIDTH; no overflow flag.
REQ-020 slt: signed two's-complement compare, result = {WIDTH-1 zeros, a<b}.
REQ-021 States IDLE, BUSY, DONE; in_ready = 1 only in IDLE.
REQ-022 IDLE + transfer in of non-multiply op -> DONE; outputs registered; out_valid=1 on the following cycle (latency 1).
REQ-023 IDLE + transfer in of multu -> BUSY; iterative unsigned shift-add, one multiplier bit per cycle, exactly WIDTH cycles in BUSY, then DONE with {result_hi,result} = a*b (latency WIDTH+1).
REQ-024 BUSY ignores in_valid, out_ready and input operand changes; operands captured at transfer in.
REQ-025 DONE holds result, result_hi, zero, alu_ctl, illegal stable until transfer out, then -> IDLE; no new accept in the same cycle (max throughput one op per 2 cycles).
REQ-026 zero computed from result only, including for multu and illegal ops.

Reset
REQ-027 reset asserted at any time (including BUSY mid-multiply) -> state IDLE immediately, in-flight op discarded.
REQ-028 Reset values: out_valid=0, result=0, result_hi=0, zero=1, alu_ctl=0000, illegal=0; in_ready=1 after reset deasserts.

Configuration
REQ-029 Macro ALU_EXEC_MULT_EN: defined -> multu decoded and multiplier datapath/BUSY state present.
REQ-030 Without ALU_EXEC_MULT_EN -> func_code 011001 treated as illegal per REQ-018, BUSY unreachable, result_hi constant 0.

Verification
REQ-031 WIDTH=32, alu_op=10, funct=100000, a=0xFFFFFFFF, b=1 -> next cycle out_valid=1, result=0, zero=1, alu_ctl=0010.
REQ-032 alu_op=10, funct=101010, a=0xFFFFFFFE (-2), b=1 -> result=1, alu_ctl=0111; swap operands -> result=0, zero=1.
REQ-033 MULT_EN, funct=011001, a=0xFFFFFFFF, b=2 -> out_valid exactly 33 cycles after accept, result_hi=1, result=0xFFFFFFFE; in_ready=0 throughout.
REQ-034 Result held with out_ready=0 for 5 cycles -> all outputs stable, in_ready=0; out_ready=1 -> IDLE next cycle, in_ready=1.
REQ-035 funct=111111, alu_op=10 -> illegal=1, alu_ctl=1111, result=0; without MULT_EN, funct=011001 -> same response.
REQ-036 reset pulsed 10 cycles into a multu -> out_valid=0, result=0 immediately; next add of 3+4 returns 7 with latency 1.
